mm_dma_mc: RTL and testbench

- Parametrised multi-channel successor to the single-pair matrix DMA in the user project.
- Fetches LEN words from each of NUM_RD_CH source arrays in SDRAM through a Wishbone master port.
- Streams those words to the compute engine over AXI-Stream, and writes LEN result words back to a destination array.
- Configured and started by the CPU through a Wishbone slave register window; sits between the CPU, the SDRAM arbiter and the engine.

---
 rtl/mm_dma_mc.sv | 348 ++++++++++++++++++++++++++++++++++
 tb/tb_mm_dma_mc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_dma_mc.sv
// rtl/mm_dma_mc.sv - multi-channel matrix DMA: Wishbone reg slave, Wishbone master, AXI-Stream engine ports
//
// Fetches LEN words from each of NUM_RD_CH source arrays, streams them to the
// compute engine (ss_*), collects LEN result words (sm_*) and writes them to DST.
//
// Ports:
//   wb_clk_i, wb_rst_n_i       clock, synchronous active-low reset
//   wbs_*                      register slave (CTRL, LEN, SRC_i, DST)
//   dma_*                      memory master, one transaction at a time
//   ss_tdata/tvalid/tready     words to the engine; tuser = channel, tlast = end of channel/group
//   ss_tlast/tuser
//   sm_tdata/tvalid/tready     result words from the engine
//   irq_o                      level interrupt, only when MM_DMA_IRQ_EN is defined
//
// Optional feature macro: MM_DMA_IRQ_EN (adds irq_o and the CTRL bit4 irq enable).

module mm_dma_mc #(
    parameter int          NUM_RD_CH     = 2,
    parameter int          RD_FIFO_DEPTH = 4,
    parameter int          WR_FIFO_DEPTH = 4,
    parameter int          LEN_W         = 16,
    parameter logic [31:0] REG_BASE      = 32'h3000_0080
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dma_stb_o,
    output logic        dma_cyc_o,
    output logic        dma_we_o,
    output logic [3:0]  dma_sel_o,
    output logic [31:0] dma_adr_o,
    output logic [31:0] dma_dat_o,
    input  logic        dma_ack_i,
    input  logic [31:0] dma_dat_i,
    output logic        ss_tvalid,
    output logic        ss_tlast,
    output logic [31:0] ss_tdata,
    output logic [1:0]  ss_tuser,
    input  logic        ss_tready,
`ifdef MM_DMA_IRQ_EN
    output logic        irq_o,
`endif
    input  logic        sm_tvalid,
    input  logic [31:0] sm_tdata,
    output logic        sm_tready
);

    localparam int CH_W  = (NUM_RD_CH > 1) ? $clog2(NUM_RD_CH) : 1;
    localparam int RA_W  = $clog2(RD_FIFO_DEPTH);
    localparam int WA_W  = $clog2(WR_FIFO_DEPTH);
    localparam int CNT_W = LEN_W + 2;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_WR, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [31:0]        rdat_q, rdat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [31:0]        src_q [NUM_RD_CH];
    logic [31:0]        src_d [NUM_RD_CH];
    logic [31:0]        dst_q, dst_d;
    logic               mode_q, mode_d;
    logic               irq_en_q, irq_en_d;
    logic               done_q, done_d;
    logic               stb_q, stb_d;
    logic               we_q, we_d;
    logic [31:0]        adr_q, adr_d;
    logic [31:0]        wdat_q, wdat_d;
    logic [CH_W-1:0]    rd_ch_q, rd_ch_d;
    logic [LEN_W-1:0]   rd_k_q, rd_k_d;
    logic [CNT_W-1:0]   reads_q, reads_d;
    logic [LEN_W-1:0]   writes_q, writes_d;

    // Read FIFO entry: {tlast, tuser, tdata}
    logic [34:0]        rd_mem_q [RD_FIFO_DEPTH];
    logic [34:0]        rd_mem_d [RD_FIFO_DEPTH];
    logic [RA_W-1:0]    rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [RA_W:0]      rd_cnt_q, rd_cnt_d;
    logic [31:0]        wr_mem_q [WR_FIFO_DEPTH];
    logic [31:0]        wr_mem_d [WR_FIFO_DEPTH];
    logic [WA_W-1:0]    wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [WA_W:0]      wr_cnt_q, wr_cnt_d;

    logic               busy, in_win, req, wr_req, start, ctrl_wr, cfg_ok;
    logic [2:0]         reg_idx;
    logic [31:0]        rdata;
    logic [CNT_W-1:0]   total_rd;
    logic [31:0]        rd_addr;
    logic               rd_last, rd_push, rd_pop, wr_push, wr_pop;
    logic               rd_full, wr_full;
    logic               unused_ok;

    assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

    // busy is deliberately low in DONE so CTRL shows done=1/busy=0 together
    assign busy     = (state_q == S_ARB) || (state_q == S_RD) || (state_q == S_WR);
    assign cfg_ok   = (state_q == S_IDLE);
    assign in_win   = (wbs_adr_i[31:5] == REG_BASE[31:5]);
    // ~ack_q lets a master that holds stb through the ack cycle get exactly one ack
    assign req      = wbs_stb_i & wbs_cyc_i & in_win & ~ack_q;
    assign wr_req   = req & wbs_we_i;
    assign reg_idx  = wbs_adr_i[4:2];
    assign ctrl_wr  = wr_req & (reg_idx == 3'd0);
    assign start    = ctrl_wr & wbs_dat_i[0] & cfg_ok;
    assign total_rd = CNT_W'(len_q) * CNT_W'(NUM_RD_CH);
    assign rd_addr  = src_q[rd_ch_q] + (32'(rd_k_q) << 2);
    assign rd_last  = mode_q ? (rd_ch_q == CH_W'(NUM_RD_CH - 1))
                             : (rd_k_q == len_q - LEN_W'(1));
    assign rd_full  = (rd_cnt_q == (RA_W+1)'(RD_FIFO_DEPTH));
    assign wr_full  = (wr_cnt_q == (WA_W+1)'(WR_FIFO_DEPTH));

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign dma_stb_o = stb_q;
    assign dma_cyc_o = stb_q;
    assign dma_we_o  = we_q;
    assign dma_sel_o = 4'hF;
    assign dma_adr_o = adr_q;
    assign dma_dat_o = wdat_q;
    assign ss_tvalid = (rd_cnt_q != '0);
    assign ss_tdata  = ss_tvalid ? rd_mem_q[rd_rp_q][31:0] : 32'd0;
    assign ss_tuser  = ss_tvalid ? rd_mem_q[rd_rp_q][33:32] : 2'd0;
    assign ss_tlast  = ss_tvalid & rd_mem_q[rd_rp_q][34];
    assign sm_tready = ~wr_full;
    assign rd_pop    = ss_tvalid & ss_tready;
    // Engine words arriving while not busy are accepted and discarded
    assign wr_push   = sm_tvalid & ~wr_full & busy;
`ifdef MM_DMA_IRQ_EN
    assign irq_o     = done_q & irq_en_q;
`endif

    always_comb begin
        rdata = 32'd0;
        case (reg_idx)
            3'd0:    rdata = {27'd0, irq_en_q, mode_q, busy, done_q, 1'b0};
            3'd1:    rdata = 32'(len_q);
            3'd6:    rdata = dst_q;
            default: begin
                for (int i = 0; i < NUM_RD_CH; i++)
                    if (reg_idx == 3'(i + 2)) rdata = src_q[i];
            end
        endcase
    end

    always_comb begin
        ack_d    = req;
        rdat_d   = (req & ~wbs_we_i) ? rdata : 32'd0;
        len_d    = len_q;
        src_d    = src_q;
        dst_d    = dst_q;
        mode_d   = mode_q;
        irq_en_d = irq_en_q;
        if (wr_req && cfg_ok) begin
            if (reg_idx == 3'd1) len_d = wbs_dat_i[LEN_W-1:0];
            if (reg_idx == 3'd6) dst_d = wbs_dat_i;
            for (int i = 0; i < NUM_RD_CH; i++)
                if (reg_idx == 3'(i + 2)) src_d[i] = wbs_dat_i;
        end
        if (ctrl_wr && cfg_ok) mode_d = wbs_dat_i[3];
`ifdef MM_DMA_IRQ_EN
        if (ctrl_wr) irq_en_d = wbs_dat_i[4];
`else
        irq_en_d = 1'b0;
`endif
    end

    always_comb begin
        state_d  = state_q;
        stb_d    = 1'b0;
        we_d     = 1'b0;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rd_ch_d  = rd_ch_q;
        rd_k_d   = rd_k_q;
        reads_d  = reads_q;
        writes_d = writes_q;
        rd_push  = 1'b0;
        wr_pop   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_ARB;
                    rd_ch_d  = '0;
                    rd_k_d   = '0;
                    reads_d  = '0;
                    writes_d = '0;
                end
            end
            S_ARB: begin
                if (wr_cnt_q != '0 && writes_q < len_q) begin
                    state_d = S_WR;
                    stb_d   = 1'b1;
                    we_d    = 1'b1;
                    adr_d   = dst_q + (32'(writes_q) << 2);
                    wdat_d  = wr_mem_q[wr_rp_q];
                end else if (reads_q < total_rd && !rd_full) begin
                    state_d = S_RD;
                    stb_d   = 1'b1;
                    adr_d   = rd_addr;
                end else if (writes_q == len_q && reads_q == total_rd) begin
                    state_d = S_DONE;
                end
            end
            S_RD: begin
                if (dma_ack_i) begin
                    state_d = S_ARB;
                    rd_push = 1'b1;
                    reads_d = reads_q + CNT_W'(1);
                    if (mode_q) begin
                        if (rd_ch_q == CH_W'(NUM_RD_CH - 1)) begin
                            rd_ch_d = '0;
                            rd_k_d  = rd_k_q + LEN_W'(1);
                        end else begin
                            rd_ch_d = rd_ch_q + CH_W'(1);
                        end
                    end else begin
                        if (rd_k_q == len_q - LEN_W'(1)) begin
                            rd_k_d  = '0;
                            rd_ch_d = rd_ch_q + CH_W'(1);
                        end else begin
                            rd_k_d  = rd_k_q + LEN_W'(1);
                        end
                    end
                end else begin
                    stb_d = 1'b1;
                end
            end
            S_WR: begin
                if (dma_ack_i) begin
                    state_d  = S_ARB;
                    wr_pop   = 1'b1;
                    writes_d = writes_q + LEN_W'(1);
                end else begin
                    stb_d = 1'b1;
                    we_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        done_d = done_q;
        if (ctrl_wr && wbs_dat_i[1]) done_d = 1'b0;
        if (start) done_d = 1'b0;
        if (state_d == S_DONE) done_d = 1'b1;
    end

    always_comb begin
        rd_mem_d = rd_mem_q;
        rd_wp_d  = rd_wp_q;
        rd_rp_d  = rd_rp_q;
        rd_cnt_d = rd_cnt_q;
        if (rd_push) begin
            rd_mem_d[rd_wp_q] = {rd_last, 2'(rd_ch_q), dma_dat_i};
            rd_wp_d = rd_wp_q + RA_W'(1);
        end
        if (rd_pop) rd_rp_d = rd_rp_q + RA_W'(1);
        if (rd_push && !rd_pop) rd_cnt_d = rd_cnt_q + (RA_W+1)'(1);
        if (!rd_push && rd_pop) rd_cnt_d = rd_cnt_q - (RA_W+1)'(1);
    end

    always_comb begin
        wr_mem_d = wr_mem_q;
        wr_wp_d  = wr_wp_q;
        wr_rp_d  = wr_rp_q;
        wr_cnt_d = wr_cnt_q;
        if (!busy) begin
            // Leftover results from a finished transfer are discarded
            wr_wp_d  = '0;
            wr_rp_d  = '0;
            wr_cnt_d = '0;
        end else begin
            if (wr_push) begin
                wr_mem_d[wr_wp_q] = sm_tdata;
                wr_wp_d = wr_wp_q + WA_W'(1);
            end
            if (wr_pop) wr_rp_d = wr_rp_q + WA_W'(1);
            if (wr_push && !wr_pop) wr_cnt_d = wr_cnt_q + (WA_W+1)'(1);
            if (!wr_push && wr_pop) wr_cnt_d = wr_cnt_q - (WA_W+1)'(1);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            len_q    <= '0;
            for (int i = 0; i < NUM_RD_CH; i++) src_q[i] <= '0;
            dst_q    <= '0;
            mode_q   <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            rd_ch_q  <= '0;
            rd_k_q   <= '0;
            reads_q  <= '0;
            writes_q <= '0;
            for (int i = 0; i < RD_FIFO_DEPTH; i++) rd_mem_q[i] <= '0;
            rd_wp_q  <= '0;
            rd_rp_q  <= '0;
            rd_cnt_q <= '0;
            for (int i = 0; i < WR_FIFO_DEPTH; i++) wr_mem_q[i] <= '0;
            wr_wp_q  <= '0;
            wr_rp_q  <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            len_q    <= len_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            mode_q   <= mode_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            rd_ch_q  <= rd_ch_d;
            rd_k_q   <= rd_k_d;
            reads_q  <= reads_d;
            writes_q <= writes_d;
            rd_mem_q <= rd_mem_d;
            rd_wp_q  <= rd_wp_d;
            rd_rp_q  <= rd_rp_d;
            rd_cnt_q <= rd_cnt_d;
            wr_mem_q <= wr_mem_d;
            wr_wp_q  <= wr_wp_d;
            wr_rp_q  <= wr_rp_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

endmodule

// File: tb/tb_mm_dma_mc.sv
// tb/tb_mm_dma_mc.sv - directed self-checking bench for mm_dma_mc
module tb_mm_dma_mc;

    localparam logic [31:0] BASE = 32'h3000_0080;
    localparam logic [31:0] S0   = 32'h3800_0000;
    localparam logic [31:0] S1   = 32'h3800_0040;
    localparam logic [31:0] DST  = 32'h3800_0080;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'hF;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        dma_stb_o, dma_cyc_o, dma_we_o;
    logic [3:0]  dma_sel_o;
    logic [31:0] dma_adr_o, dma_dat_o;
    logic        dma_ack_i = 1'b0;
    logic [31:0] dma_dat_i = '0;
    logic        ss_tvalid, ss_tlast;
    logic [31:0] ss_tdata;
    logic [1:0]  ss_tuser;
    logic        ss_tready = 1'b1;
    logic        sm_tvalid = 1'b0;
    logic [31:0] sm_tdata = '0;
    logic        sm_tready;
`ifdef MM_DMA_IRQ_EN
    logic        irq_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rd_log[$], wr_adr_log[$], wr_dat_log[$], beat_dat[$], echo_q[$];
    logic [1:0]  beat_usr[$];
    logic        beat_lst[$];
    bit          ss_hold = 0, ack_hold = 0, cyc_seen = 0, sm_fire = 0;

    always #5 clk = ~clk;

    mm_dma_mc dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .dma_stb_o(dma_stb_o), .dma_cyc_o(dma_cyc_o), .dma_we_o(dma_we_o),
        .dma_sel_o(dma_sel_o), .dma_adr_o(dma_adr_o), .dma_dat_o(dma_dat_o),
        .dma_ack_i(dma_ack_i), .dma_dat_i(dma_dat_i),
        .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tdata(ss_tdata),
        .ss_tuser(ss_tuser), .ss_tready(ss_tready),
`ifdef MM_DMA_IRQ_EN
        .irq_o(irq_o),
`endif
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tready(sm_tready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h0F0F_5A5A;
    endfunction

    // SDRAM responder and echoing engine; decisions are made at negedge for the next posedge
    always @(negedge clk) begin
        if (dma_cyc_o) cyc_seen = 1;
        if (dma_stb_o && dma_cyc_o && !dma_ack_i && !ack_hold) begin
            dma_ack_i = 1'b1;
            if (dma_we_o) begin
                wr_adr_log.push_back(dma_adr_o);
                wr_dat_log.push_back(dma_dat_o);
            end else begin
                rd_log.push_back(dma_adr_o);
                dma_dat_i = mem_word(dma_adr_o);
            end
        end else begin
            dma_ack_i = 1'b0;
        end
        if (sm_fire) void'(echo_q.pop_front());
        if (echo_q.size() > 0) begin
            sm_tvalid = 1'b1;
            sm_tdata  = echo_q[0];
        end else begin
            sm_tvalid = 1'b0;
            sm_tdata  = '0;
        end
        sm_fire   = sm_tvalid && sm_tready;
        ss_tready = !ss_hold;
        if (ss_tvalid && ss_tready) begin
            beat_dat.push_back(ss_tdata);
            beat_usr.push_back(ss_tuser);
            beat_lst.push_back(ss_tlast);
            echo_q.push_back(ss_tdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        wbs_adr_i = a; wbs_dat_i = d; wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
        @(posedge clk); #1;
        check("wr_ack", wbs_ack_o, 1);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wbs_adr_i = a; wbs_we_i = 0; wbs_stb_i = 1; wbs_cyc_i = 1;
        @(posedge clk); #1;
        check("rd_ack", wbs_ack_o, 1);
        d = wbs_dat_o;
        wbs_stb_i = 0; wbs_cyc_i = 0;
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < 2000 && !v[1]; i++) wb_read(BASE, v);
        check({tag, "_done"}, 32'(v[1]), 1);
        check({tag, "_busy"}, 32'(v[2]), 0);
    endtask

    task automatic drain(input string tag);
        int i;
        for (i = 0; i < 300 && (echo_q.size() != 0 || ss_tvalid); i++) @(posedge clk);
        #1;
        check({tag, "_drained"}, 32'(echo_q.size() == 0 && !ss_tvalid), 1);
    endtask

    task automatic clear_logs();
        rd_log.delete(); wr_adr_log.delete(); wr_dat_log.delete();
        beat_dat.delete(); beat_usr.delete(); beat_lst.delete();
    endtask

    task automatic check_run(input string tag, input bit il, input int len);
        int ch, k;
        logic [31:0] a;
        logic [31:0] exp_a[$];
        check({tag, "_nreads"}, rd_log.size(), 2 * len);
        check({tag, "_nbeats"}, beat_dat.size(), 2 * len);
        for (int i = 0; i < 2 * len; i++) begin
            ch = il ? i % 2 : i / len;
            k  = il ? i / 2 : i % len;
            a  = (ch == 0 ? S0 : S1) + 32'(4 * k);
            exp_a.push_back(a);
            check({tag, "_rd_adr"}, rd_log[i], a);
            check({tag, "_beat_dat"}, beat_dat[i], mem_word(a));
            check({tag, "_beat_user"}, 32'(beat_usr[i]), ch);
            check({tag, "_beat_last"}, 32'(beat_lst[i]), il ? (ch == 1) : (k == len - 1));
        end
        check({tag, "_nwrites"}, wr_adr_log.size(), len);
        for (int j = 0; j < len; j++) begin
            check({tag, "_wr_adr"}, wr_adr_log[j], DST + 32'(4 * j));
            check({tag, "_wr_dat"}, wr_dat_log[j], mem_word(exp_a[j]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] v;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wbs_ack", wbs_ack_o, 0);
        check("rst_wbs_dat", wbs_dat_o, 0);
        check("rst_dma_cyc", {dma_stb_o, dma_cyc_o, dma_we_o}, 0);
        check("rst_dma_adr", dma_adr_o, 0);
        check("rst_ss_tvalid", {ss_tvalid, ss_tlast, ss_tuser}, 0);
        check("rst_sm_tready", sm_tready, 1);
        check("dma_sel", dma_sel_o, 4'hF);
`ifdef MM_DMA_IRQ_EN
        check("rst_irq", irq_o, 0);
`endif
        rst_n = 1;
        @(posedge clk); #1;
        wb_read(BASE, v);
        check("ctrl_after_rst", v, 0);

        // outside the window: never acked
        wbs_adr_i = BASE + 32'h20; wbs_dat_i = 32'h1; wbs_we_i = 1; wbs_stb_i = 1; wbs_cyc_i = 1;
        @(posedge clk); #1;
        check("oow_ack_1", wbs_ack_o, 0);
        @(posedge clk); #1;
        check("oow_ack_2", wbs_ack_o, 0);
        wbs_adr_i = BASE - 32'h4;
        @(posedge clk); #1;
        check("oow_ack_below", wbs_ack_o, 0);
        wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        @(posedge clk); #1;

        wb_write(BASE + 32'h08, S0);
        wb_write(BASE + 32'h0C, S1);
        wb_write(BASE + 32'h18, DST);
        wb_write(BASE + 32'h04, 32'd16);
        wb_read(BASE + 32'h04, v);
        check("len_rb", v, 16);
        wb_read(BASE + 32'h0C, v);
        check("src1_rb", v, S1);
        wb_write(BASE + 32'h1C, 32'hFFFF_FFFF);
        wb_read(BASE + 32'h1C, v);
        check("reserved_rd", v, 0);

        // channel-major transfer
        clear_logs();
        wb_write(BASE, 32'h1);
        wait_done("cm");
        drain("cm");
        check_run("cm", 0, 16);
        wb_read(BASE, v);
        check("cm_ctrl", v, 32'h2);

        // interleave transfer
        wb_write(BASE, 32'h2);
        wb_read(BASE, v);
        check("w1c_done", v, 0);
        clear_logs();
        wb_write(BASE, 32'h9);
        wait_done("il");
        drain("il");
        check_run("il", 1, 16);

        // engine backpressure; LEN write while busy must be ignored
        wb_write(BASE, 32'h2);
        clear_logs();
        ss_hold = 1;
        wb_write(BASE, 32'h1);
        wb_write(BASE + 32'h04, 32'd5);
        repeat (20) @(posedge clk);
        #1;
        check("bp_reads", rd_log.size(), 4);
        check("bp_idle_cyc", dma_cyc_o, 0);
        ss_hold = 0;
        wait_done("bp");
        drain("bp");
        check_run("bp", 0, 16);
        wb_read(BASE + 32'h04, v);
        check("busy_len_ignored", v, 16);

        // LEN=0: done quickly, no master traffic
        wb_write(BASE, 32'h2);
        wb_write(BASE + 32'h04, 32'd0);
        clear_logs();
        cyc_seen = 0;
        wb_write(BASE, 32'h1);
        wb_read(BASE, v);
        check("len0_ctrl", v, 32'h2);
        repeat (4) @(posedge clk);
        #1;
        check("len0_no_cyc", cyc_seen, 0);

`ifdef MM_DMA_IRQ_EN
        wb_write(BASE, 32'h2);
        wb_write(BASE + 32'h04, 32'd4);
        clear_logs();
        wb_write(BASE, 32'h11);
        wait_done("irq");
        check("irq_set", irq_o, 1);
        drain("irq");
        wb_write(BASE, 32'h2);
        check("irq_clr", irq_o, 0);
`endif

        // reset while a read request is outstanding
        wb_write(BASE, 32'h2);
        wb_write(BASE + 32'h04, 32'd16);
        ack_hold = 1;
        wb_write(BASE, 32'h1);
        for (int i = 0; i < 50 && !dma_stb_o; i++) begin
            @(posedge clk); #1;
        end
        check("mid_rd_stb", dma_stb_o, 1);
        rst_n = 0;
        @(posedge clk); #1;
        check("mid_rst_stb", {dma_stb_o, dma_cyc_o}, 0);
        check("mid_rst_fifo", ss_tvalid, 0);
        check("mid_rst_tready", sm_tready, 1);
        ack_hold = 0;
        rst_n = 1;
        @(posedge clk); #1;
        wb_read(BASE, v);
        check("mid_rst_ctrl", v, 0);
        wb_read(BASE + 32'h04, v);
        check("mid_rst_len", v, 0);
        wb_read(BASE + 32'h18, v);
        check("mid_rst_dst", v, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
